// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for a shared 3:1 datapath mux with valid/ready toward one sink.
// Supports locked multi-beat ownership, capped at HOLD_MAX beats per grant.
module mux3_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [2:0]       REQ,
    input  logic [2:0]       LOCK,
    input  logic             OUT_READY,
    output logic [2:0]       GNT,
    output logic [1:0]       Sel,
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic [CNT_W-1:0] BEAT_CNT
);

    localparam logic       IDLE  = 1'b0;
    localparam logic       GRANT = 1'b1;
    localparam logic [1:0] NONE  = 2'd3;

    logic             state, nxt_state;
    logic [1:0]       last, nxt_last, nxt_sel, win;
    logic [2:0]       nxt_gnt, others, cand;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W:0]   cnt_inc, hold_lim;
    logic             owner_req, owner_lock, xfer, keep;

    // Search starts just after the last winner and wraps; NONE means no candidate.
    function automatic logic [1:0] pick(input logic [2:0] c, input logic [1:0] lw);
        logic [1:0] r;
        r = NONE;
        case (lw)
            2'd0: begin
                if (c[1]) r = 2'd1;
                else if (c[2]) r = 2'd2;
                else if (c[0]) r = 2'd0;
            end
            2'd1: begin
                if (c[2]) r = 2'd2;
                else if (c[0]) r = 2'd0;
                else if (c[1]) r = 2'd1;
            end
            default: begin
                if (c[0]) r = 2'd0;
                else if (c[1]) r = 2'd1;
                else if (c[2]) r = 2'd2;
            end
        endcase
        return r;
    endfunction

    assign BUSY       = (state == GRANT);
    assign owner_req  = |(REQ & GNT);
    assign owner_lock = |(LOCK & GNT);
    assign OUT_VALID  = BUSY & owner_req;

    assign cnt_inc  = {1'b0, BEAT_CNT} + {{CNT_W{1'b0}}, 1'b1};
    assign hold_lim = (CNT_W+1)'(HOLD_MAX);

    always_comb begin
        xfer   = OUT_VALID & OUT_READY;
        keep   = xfer & owner_lock & (cnt_inc < hold_lim);
        // The current owner only competes again when nobody else is asking.
        others = REQ & ~GNT;
        cand   = (BUSY && (others != 3'b000)) ? others : REQ;
        win    = pick(cand, last);

        nxt_state = state;
        nxt_gnt   = GNT;
        nxt_sel   = Sel;
        nxt_cnt   = BEAT_CNT;
        nxt_last  = last;

        if (keep) begin
            nxt_cnt = cnt_inc[CNT_W-1:0];
        end else if (!BUSY || xfer || !owner_req) begin
            nxt_cnt = '0;
            if (win == NONE) begin
                nxt_state = IDLE;
                nxt_gnt   = 3'b000;
                nxt_sel   = 2'b00;
            end else begin
                nxt_state = GRANT;
                nxt_gnt   = 3'b001 << win;
                nxt_sel   = win;
                nxt_last  = win;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            GNT      <= 3'b000;
            Sel      <= 2'b00;
            BEAT_CNT <= '0;
            last     <= 2'd2;
        end else begin
            state    <= nxt_state;
            GNT      <= nxt_gnt;
            Sel      <= nxt_sel;
            BEAT_CNT <= nxt_cnt;
            last     <= nxt_last;
        end
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-free behavioural ownership model.
module tb_mux3_rr_arbiter;

    localparam int HM = 4;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [2:0] REQ;
    logic [2:0] LOCK;
    logic       OUT_READY;
    logic [2:0] GNT;
    logic [1:0] Sel;
    logic       OUT_VALID;
    logic       BUSY;
    logic [3:0] BEAT_CNT;

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 when idle), beats done by owner, last winner.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 2;

    mux3_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .REQ       (REQ),
        .LOCK      (LOCK),
        .OUT_READY (OUT_READY),
        .GNT       (GNT),
        .Sel       (Sel),
        .OUT_VALID (OUT_VALID),
        .BUSY      (BUSY),
        .BEAT_CNT  (BEAT_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] c);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_last + k) % 3;
            if (c[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [1:0] enc(input logic [2:0] g);
        case (g)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check_all();
        logic [2:0] eg;
        logic [1:0] es;
        logic       ev;
        eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        ev = (m_owner >= 0) && REQ[m_owner];
        chk("gnt", 32'(GNT), 32'(eg));
        chk("sel", 32'(Sel), 32'(es));
        chk("busy", 32'(BUSY), 32'(m_owner >= 0));
        chk("beat_cnt", 32'(BEAT_CNT), 32'(m_cnt));
        chk("out_valid", 32'(OUT_VALID), 32'(ev));
        chk("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
        chk("sel_not_3", 32'(Sel != 2'b11), 32'd1);
        if (BUSY) chk("sel_enc", 32'(Sel), 32'(enc(GNT)));
    endtask

    // Advance one clock edge in both the DUT and the model, then compare.
    task automatic tick();
        logic [2:0] cand;
        logic [2:0] mine;
        logic       xfer;
        int         w;
        @(posedge CLK);
        if (!RESET_N) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = 2;
        end else if (m_owner < 0) begin
            w = pick(REQ);
            if (w >= 0) begin
                m_owner = w; m_cnt = 0; m_last = w;
            end
        end else begin
            xfer = REQ[m_owner] && OUT_READY;
            mine = 3'(1 << m_owner);
            if (xfer && LOCK[m_owner] && (m_cnt + 1 < HM)) begin
                m_cnt++;
            end else if (xfer || !REQ[m_owner]) begin
                cand = ((REQ & ~mine) != 3'b000) ? (REQ & ~mine) : REQ;
                w = pick(cand);
                m_cnt = 0;
                if (w < 0) m_owner = -1;
                else begin
                    m_owner = w; m_last = w;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        RESET_N = 1'b0; REQ = 3'b000; LOCK = 3'b000; OUT_READY = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);

        // 1: single requester, regranted after its beat
        RESET_N = 1'b1; REQ = 3'b001; OUT_READY = 1'b1;
        tick();
        chk("t1_gnt", 32'(GNT), 32'b001);
        chk("t1_valid", 32'(OUT_VALID), 32'd1);
        tick();
        chk("t1_regnt", 32'(GNT), 32'b001);
        chk("t1_cnt", 32'(BEAT_CNT), 32'd0);

        // 2: rotation with all requesting
        REQ = 3'b111;
        tick(); chk("t2_g1", 32'(GNT), 32'b010); chk("t2_s1", 32'(Sel), 32'd1);
        tick(); chk("t2_g2", 32'(GNT), 32'b100); chk("t2_s2", 32'(Sel), 32'd2);
        tick(); chk("t2_g3", 32'(GNT), 32'b001); chk("t2_s3", 32'(Sel), 32'd0);
        tick(); chk("t2_g4", 32'(GNT), 32'b010);

        // 3: locked burst capped at HOLD_MAX beats
        REQ = 3'b000;
        tick(); chk("t3_idle", 32'(GNT), 32'd0);
        REQ = 3'b011; LOCK = 3'b001;
        tick(); chk("t3_g", 32'(GNT), 32'b001);
        for (int b = 1; b < HM; b++) begin
            tick(); chk("t3_cnt", 32'(BEAT_CNT), 32'(b));
        end
        tick(); chk("t3_handoff", 32'(GNT), 32'b010); chk("t3_cnt0", 32'(BEAT_CNT), 32'd0);

        // 4: back-pressure holds everything
        OUT_READY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(); chk("t4_gnt", 32'(GNT), 32'b010); chk("t4_sel", 32'(Sel), 32'd1);
        end
        OUT_READY = 1'b1;
        tick(); chk("t4_done", 32'(GNT), 32'b001);

        // 5: owner drops request without a transfer
        REQ = 3'b100; LOCK = 3'b000;
        tick(); chk("t5_own2", 32'(GNT), 32'b100);
        REQ = 3'b001;
        tick(); chk("t5_to0", 32'(GNT), 32'b001); chk("t5_sel", 32'(Sel), 32'd0);
        REQ = 3'b000;
        tick(); chk("t5_idle", 32'(GNT), 32'd0);

        // 6: reset in the middle of a locked burst
        REQ = 3'b010; LOCK = 3'b010;
        tick();
        tick(); chk("t6_cnt", 32'(BEAT_CNT), 32'd1);
        RESET_N = 1'b0;
        tick(); chk("t6_gnt", 32'(GNT), 32'd0); chk("t6_cnt0", 32'(BEAT_CNT), 32'd0);
        RESET_N = 1'b1; REQ = 3'b111; LOCK = 3'b000;
        tick(); chk("t6_first", 32'(GNT), 32'b001);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) REQ = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) LOCK = 3'($urandom_range(0, 7));
            OUT_READY = ($urandom_range(0, 3) != 0);
            RESET_N = ($urandom_range(0, 80) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
